alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
Registered execute stage of the datapath. It consumes the 4-bit ALU operation code from the ALU control decoder plus two operands, computes the result, and presents it downstream.
- Valid/ready handshake on both sides.
- Two-entry skid buffer, so in_ready is driven from a flop and full throughput is kept under backpressure.
- Saturating count of completed operations for performance debug.

Parameters:
WIDTH, 32, operand and result width in bits
CNT_W, 16, width of the completed-operation counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream has an operation
in_ready  out  1  stage can accept; driven directly from a flop
aluoperation  in  4  operation code from ALU control
src_a  in  WIDTH  operand A
src_b  in  WIDTH  operand B
out_valid  out  1  result available
out_ready  in  1  downstream accepts the result
result  out  WIDTH  computed value
zero  out  1  result == 0
illegal_op  out  1  the op code for this result was unsupported
op_count  out  CNT_W  completed output transfers, saturating

Behaviour:
- Reset (asynchronous assert, synchronous release): out_valid=0, in_ready=1, result=0, zero=0, illegal_op=0, op_count=0. Both buffer entries become invalid.
- Reset mid-operation: buffered results are discarded and are not counted.
- Op codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD, modulo 2^WIDTH, carry dropped
  - 0110 SUB, a-b modulo 2^WIDTH
  - 0111 SLT, signed compare; result is 1 or 0, zero-extended
  - 1100 NOR
  - Any other code: result=0, illegal_op=1, zero=1. The transfer still completes normally.
- Flag timing: zero and illegal_op are computed at acceptance and stored with the result. They are meaningful only while out_valid=1.
- Accept rule: an input is accepted on a rising edge when in_valid && in_ready.
- Latency: an input accepted at edge N appears at the output after edge N, provided the main entry is empty or draining at edge N.
- Main entry drives the outputs. Skid entry holds the overflow.
  - Accept while main is empty, or main is draining (out_valid && out_ready): the new result loads into main.
  - Accept while main is full and stalled (out_valid && !out_ready): the new result loads into skid.
  - in_ready deasserts the cycle after skid fills.
  - When main drains and skid is full: skid moves to main, and skid empties the same edge. in_ready reasserts the next cycle.
- Stability: while out_valid && !out_ready, result, zero and illegal_op hold stable and out_valid stays 1.
- Simultaneous accept and drain with skid empty: main reloads with the new result and out_valid stays 1.
- Simultaneous skid-to-main move and accept: this cannot occur, because in_ready=0 whenever skid is full.
- Ordering: results leave in acceptance order; none are dropped or duplicated.
- Throughput: one op per cycle when out_ready is held high.
- Input legality: in_valid may drop without a transfer. Inputs are sampled only on an accept edge.
- op_count:
  - Increments by 1 on each edge where out_valid && out_ready.
  - Holds at 2^CNT_W-1; never wraps.

Test Plan:
1. Reset, then ADD a=0x0000_0005, b=0x0000_0003 with out_ready=1 -> next cycle out_valid=1, result=0x8, zero=0, illegal_op=0; op_count=1 after the drain edge.
2. SUB 7-7, then SLT a=0xFFFF_FFFF, b=0x1, then ADD 0xFFFF_FFFF+1, back-to-back, out_ready=1 -> results 0 (zero=1), 1 (signed -1<1), 0 (wrap, zero=1), one per cycle.
3. Stream 4 ops with out_ready=0 from the start -> first lands in main, second in skid, in_ready=0 thereafter. Raise out_ready -> results drain in order with no loss, in_ready returns to 1 one cycle after skid empties.
4. Op 0011 with a=0xA, b=0xB -> result=0, illegal_op=1, zero=1, transfer completes. Following AND 0xF0&0x3C -> 0x30 with illegal_op=0.
5. Assert rst_n=0 with both entries full and out_ready=0 -> out_valid=0 and in_ready=1 immediately (asynchronous). After release, no stale results appear and op_count=0.
6. CNT_W=4, 20 transfers with out_ready=1 -> op_count stops at 15 and stays at 15.

Source files
------------

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with a two-entry (main + skid) output buffer.
// The main entry drives the outputs; the skid entry absorbs one extra result
// when the downstream stalls, so in_ready can come straight from a flop.
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluoperation,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal_op,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Unsupported codes yield zero so the flags stay self-consistent.
  function automatic logic [WIDTH-1:0] alu_calc(input logic [3:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    sa  = a;
    sb  = b;
    res = '0;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, (sa < sb)};
      OP_NOR:  res = ~(a | b);
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic logic op_illegal(input logic [3:0] op);
    logic ill;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: ill = 1'b0;
      default:                                       ill = 1'b1;
    endcase
    return ill;
  endfunction

  // p0: combinational compute on the incoming operation
  logic [WIDTH-1:0] w_res_p0;
  logic             w_zero_p0;
  logic             w_ill_p0;

  assign w_res_p0  = alu_calc(aluoperation, src_a, src_b);
  assign w_ill_p0  = op_illegal(aluoperation);
  assign w_zero_p0 = (w_res_p0 == '0);

  // p1: main/skid buffer entries
  logic             r_main_vld_p1;
  logic [WIDTH-1:0] r_main_res_p1;
  logic             r_main_zero_p1;
  logic             r_main_ill_p1;
  logic             r_skid_vld_p1;
  logic [WIDTH-1:0] r_skid_res_p1;
  logic             r_skid_zero_p1;
  logic             r_skid_ill_p1;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_cnt;

  logic w_acc;
  logic w_drain;
  logic w_load_main_new;
  logic w_load_skid;
  logic w_skid_to_main;
  logic w_main_vld_nxt;
  logic w_skid_vld_nxt;

  assign w_acc           = in_valid && r_in_ready;
  assign w_drain         = r_main_vld_p1 && out_ready;
  // Skid is never full while accepting, so these three are mutually exclusive.
  assign w_skid_to_main  = w_drain && r_skid_vld_p1;
  assign w_load_main_new = w_acc && (!r_main_vld_p1 || w_drain);
  assign w_load_skid     = w_acc && r_main_vld_p1 && !out_ready;

  // Next occupancy of both entries from the load/drain decisions.
  always_comb begin
    w_main_vld_nxt = r_main_vld_p1;
    w_skid_vld_nxt = r_skid_vld_p1;
    if (w_skid_to_main || w_load_main_new) begin
      w_main_vld_nxt = 1'b1;
    end else if (w_drain) begin
      w_main_vld_nxt = 1'b0;
    end
    if (w_load_skid) begin
      w_skid_vld_nxt = 1'b1;
    end else if (w_skid_to_main) begin
      w_skid_vld_nxt = 1'b0;
    end
  end

  // Occupancy flags and registered in_ready (low while skid holds a result).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_vld_p1 <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
      r_in_ready    <= 1'b1;
    end else begin
      r_main_vld_p1 <= w_main_vld_nxt;
      r_skid_vld_p1 <= w_skid_vld_nxt;
      r_in_ready    <= !w_skid_vld_nxt;
    end
  end

  // Main entry payload; cleared on reset because it is visible on the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_res_p1  <= '0;
      r_main_zero_p1 <= 1'b0;
      r_main_ill_p1  <= 1'b0;
    end else if (w_skid_to_main) begin
      r_main_res_p1  <= r_skid_res_p1;
      r_main_zero_p1 <= r_skid_zero_p1;
      r_main_ill_p1  <= r_skid_ill_p1;
    end else if (w_load_main_new) begin
      r_main_res_p1  <= w_res_p0;
      r_main_zero_p1 <= w_zero_p0;
      r_main_ill_p1  <= w_ill_p0;
    end
  end

  // Skid entry payload; only meaningful while r_skid_vld_p1 is set.
  always_ff @(posedge clk) begin
    if (w_load_skid) begin
      r_skid_res_p1  <= w_res_p0;
      r_skid_zero_p1 <= w_zero_p0;
      r_skid_ill_p1  <= w_ill_p0;
    end
  end

  // Saturating count of completed output transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_drain && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_main_vld_p1;
  assign result     = r_main_res_p1;
  assign zero       = r_main_zero_p1;
  assign illegal_op = r_main_ill_p1;
  assign op_count   = r_cnt;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed scenarios plus random
// traffic, checked against a queue-based model of the buffered results.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  aluoperation = 4'b0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, zero, illegal_op;
  logic [31:0] result;
  logic [15:0] op_count;
  logic        in_ready4, out_valid4, zero4, illegal_op4;
  logic [31:0] result4;
  logic [3:0]  op_count4;

  always #5 clk = ~clk;

  alu_exec_stage #(.WIDTH(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .aluoperation(aluoperation), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal_op(illegal_op), .op_count(op_count)
  );

  alu_exec_stage #(.WIDTH(32), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .aluoperation(aluoperation), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid4), .out_ready(out_ready), .result(result4),
    .zero(zero4), .illegal_op(illegal_op4), .op_count(op_count4)
  );

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        il;
  } exp_t;

  exp_t q[$];
  int   cnt16 = 0;
  int   cnt4  = 0;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Result of one operation straight from the op-code table.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.il = 1'b0;
    case (op)
      4'b0000: e.r = a & b;
      4'b0001: e.r = a | b;
      4'b0010: e.r = 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
      4'b0110: e.r = 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
      4'b0111: e.r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: e.r = ~(a | b);
      default: begin e.r = 32'd0; e.il = 1'b1; end
    endcase
    e.z = (e.r == 32'd0);
    return e;
  endfunction

  task automatic check_outputs();
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready4", in_ready4, q.size() < 2);
    chk("out_valid4", out_valid4, q.size() > 0);
    if (q.size() > 0) begin
      chk("result", result, q[0].r);
      chk("zero", zero, q[0].z);
      chk("illegal_op", illegal_op, q[0].il);
      chk("result4", result4, q[0].r);
    end
    chk("op_count", op_count, cnt16);
    chk("op_count4", op_count4, cnt4);
  endtask

  // Drive one cycle of inputs, check the current state, advance the model.
  task automatic step(input logic v, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic rdy);
    logic acc, drn;
    in_valid = v; aluoperation = op; src_a = a; src_b = b; out_ready = rdy;
    #1;
    check_outputs();
    acc = v && (q.size() < 2);
    drn = rdy && (q.size() > 0);
    if (drn) begin
      void'(q.pop_front());
      if (cnt16 < 65535) cnt16++;
      if (cnt4 < 15) cnt4++;
    end
    if (acc) q.push_back(model(op, a, b));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    q.delete();
    cnt16 = 0;
    cnt4 = 0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", zero, 1'b0);
    chk("rst_illegal", illegal_op, 1'b0);
    chk("rst_op_count", op_count, 16'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] edge_vals [5];
  logic [3:0]  legal_ops [6];

  initial begin
    logic [31:0] a, b;
    logic [3:0]  op;
    edge_vals = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    legal_ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};

    @(negedge clk);
    do_reset();

    // 1: single ADD
    step(1, 4'b0010, 32'h5, 32'h3, 1);
    step(0, 4'b0000, 32'h0, 32'h0, 1);
    step(0, 4'b0000, 32'h0, 32'h0, 1);

    // 2: SUB zero, SLT signed, ADD wrap back-to-back
    step(1, 4'b0110, 32'h7, 32'h7, 1);
    step(1, 4'b0111, 32'hFFFF_FFFF, 32'h1, 1);
    step(1, 4'b0010, 32'hFFFF_FFFF, 32'h1, 1);
    step(0, 4'b0000, 32'h0, 32'h0, 1);
    step(0, 4'b0000, 32'h0, 32'h0, 1);

    // 4: illegal op then AND
    step(1, 4'b0011, 32'hA, 32'hB, 1);
    step(1, 4'b0000, 32'hF0, 32'h3C, 1);
    step(0, 4'b0000, 32'h0, 32'h0, 1);
    step(0, 4'b0000, 32'h0, 32'h0, 1);

    // 3: stream 4 ops under backpressure, then release
    step(1, 4'b0010, 32'h10, 32'h1, 0);
    step(1, 4'b0010, 32'h20, 32'h2, 0);
    step(1, 4'b0010, 32'h30, 32'h3, 0);
    step(1, 4'b0010, 32'h40, 32'h4, 0);
    step(1, 4'b0010, 32'h30, 32'h3, 1);
    step(1, 4'b0010, 32'h40, 32'h4, 1);
    step(1, 4'b0001, 32'h50, 32'h5, 1);
    for (int i = 0; i < 4; i++) step(0, 4'b0000, 32'h0, 32'h0, 1);

    // 5: reset with both entries full and stalled
    step(1, 4'b0001, 32'h1, 32'h2, 0);
    step(1, 4'b0001, 32'h3, 32'h4, 0);
    step(1, 4'b0001, 32'h5, 32'h6, 0);
    #2;
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 4'b0000, 32'h0, 32'h0, 1);

    // 6: 20 transfers, 4-bit counter saturates at 15
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 4'b0010, i, 32'h1, 1);
    for (int i = 0; i < 3; i++) step(0, 4'b0000, 32'h0, 32'h0, 1);
    chk("op_count4_sat", op_count4, 4'd15);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 3) != 0) ? legal_ops[$urandom_range(0, 5)]
                                       : 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 2) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
      step($urandom_range(0, 3) != 0, op, a, b, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 4; i++) step(0, 4'b0000, 32'h0, 32'h0, 1);
    chk("drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
